// File: rtl/div_pkg.sv
// Shared constants and state encoding for the programmable clock divider.
package div_pkg;

   localparam int DIV_W_DEF       = 8;
   localparam int DEFAULT_DIV_DEF = 7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      PEND = 2'd2
   } state_t;

endpackage

// File: rtl/div_if.sv
// Ratio request handshake between a configuring agent and div_ctrl.
interface div_if
   import div_pkg::*;
#(
   parameter int DIV_W = DIV_W_DEF
) ();

   logic [DIV_W-1:0] cfg_div;
   logic             cfg_valid;
   logic             cfg_ready;
   logic             cfg_err;

   modport master (
      output cfg_div, cfg_valid,
      input  cfg_ready, cfg_err
   );

   modport slave (
      input  cfg_div, cfg_valid,
      output cfg_ready, cfg_err
   );

endinterface

// File: rtl/div_cnt.sv
// Period counter plus registered div_clk/tick, driven by the div_ctrl FSM.
module div_cnt
   import div_pkg::*;
#(
   parameter int DIV_W = DIV_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             count,
   input  logic             run_nx,
   input  logic [DIV_W-1:0] ratio,
   input  logic [DIV_W-1:0] ratio_nx,
   output logic             wrap,
   output logic             div_clk,
   output logic             tick
);

   localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] cnt_nx;

   assign wrap = (cnt == (ratio - ONE));

   always_comb begin
      cnt_nx = '0;
      if (count && !wrap) cnt_nx = cnt + ONE;
   end

   // Outputs are computed from the post-edge count and ratio so they line up
   // with cnt in the same cycle while still coming straight from flops.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt     <= '0;
         div_clk <= 1'b0;
         tick    <= 1'b0;
      end else begin
         cnt     <= cnt_nx;
         tick    <= run_nx && (cnt_nx == '0);
         div_clk <= run_nx && (cnt_nx < (ratio_nx >> 1));
      end
   end

endmodule

// File: rtl/div_ctrl.sv
// Divider control: FSM, ratio handshake and hitless ratio switching at period boundaries.
module div_ctrl
   import div_pkg::*;
#(
   parameter int DIV_W       = DIV_W_DEF,
   parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   div_if.slave             cfg,
   output logic             div_clk,
   output logic             tick,
   output logic [DIV_W-1:0] active_div,
   output logic             busy
);

   localparam logic [DIV_W-1:0] TWO = DIV_W'(2);

   state_t           state, state_nx;
   logic [DIV_W-1:0] pend_div, pend_nx, active_nx;
   logic             acc, acc_ok, wrap, count, run_nx;

   assign acc    = cfg.cfg_valid && cfg.cfg_ready;
   assign acc_ok = acc && (cfg.cfg_div >= TWO);

   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      active_nx = active_div;
      pend_nx   = pend_div;
      case (state)
         IDLE: begin
            if (acc_ok) active_nx = cfg.cfg_div;
            if (en)     state_nx  = RUN;
         end
         RUN: begin
            if (!en) begin
               state_nx = IDLE;
               if (acc_ok) active_nx = cfg.cfg_div;
            end else if (acc_ok && wrap) begin
               active_nx = cfg.cfg_div;
            end else if (acc_ok) begin
               pend_nx  = cfg.cfg_div;
               state_nx = PEND;
            end
         end
         PEND: begin
            // Pending ratio lands at the boundary, or immediately when stopping.
            if (!en || wrap) begin
               active_nx = pend_div;
               state_nx  = en ? RUN : IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      cfg.cfg_ready = rst && (state != PEND);
      busy          = (state != IDLE);
      run_nx        = (state_nx != IDLE);
      count         = (state != IDLE) && run_nx;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         active_div  <= DIV_W'(DEFAULT_DIV);
         pend_div    <= '0;
         cfg.cfg_err <= 1'b0;
      end else begin
         active_div  <= active_nx;
         pend_div    <= pend_nx;
         cfg.cfg_err <= acc && !acc_ok;
      end
   end

   div_cnt #(.DIV_W(DIV_W)) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .count    (count),
      .run_nx   (run_nx),
      .ratio    (active_div),
      .ratio_nx (active_nx),
      .wrap     (wrap),
      .div_clk  (div_clk),
      .tick     (tick)
   );

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: per-cycle expectations queued at drive time, checked after each edge.
module tb_div_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       div_clk;
   logic       tick;
   logic [7:0] active_div;
   logic       busy;

   int total = 0;
   int bad   = 0;
   int ncyc  = 0;

   typedef struct packed {
      logic       dclk;
      logic       tk;
      logic [7:0] act;
      logic       rdy;
      logic       err;
      logic       bsy;
   } exp_t;

   exp_t sb[$];

   div_if #(.DIV_W(8)) cfg ();

   div_ctrl #(.DIV_W(8), .DEFAULT_DIV(7)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .cfg        (cfg.slave),
      .div_clk    (div_clk),
      .tick       (tick),
      .active_div (active_div),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, ncyc, obs, exp);
      end
   endtask

   // Scoreboard consumer: one expectation per edge, sampled 1 time unit after it.
   always @(posedge clk) begin
      #1;
      if (sb.size() > 0) begin
         exp_t x;
         x = sb.pop_front();
         ncyc++;
         chk("div_clk",    {7'd0, div_clk},       {7'd0, x.dclk});
         chk("tick",       {7'd0, tick},          {7'd0, x.tk});
         chk("active_div", active_div,            x.act);
         chk("cfg_ready",  {7'd0, cfg.cfg_ready}, {7'd0, x.rdy});
         chk("cfg_err",    {7'd0, cfg.cfg_err},   {7'd0, x.err});
         chk("busy",       {7'd0, busy},          {7'd0, x.bsy});
      end
   end

   // Drive one cycle of inputs and queue what the outputs must be after the next edge.
   task automatic cyc(input logic r, input logic e, input logic v, input logic [7:0] d,
                      input logic eclk, input logic etick, input logic [7:0] eact,
                      input logic erdy, input logic eerr, input logic ebusy);
      exp_t x;
      @(negedge clk);
      rst           = r;
      en            = e;
      cfg.cfg_valid = v;
      cfg.cfg_div   = d;
      x = '{dclk: eclk, tk: etick, act: eact, rdy: erdy, err: eerr, bsy: ebusy};
      sb.push_back(x);
   endtask

   // Free-running cycles with en=1 and no request; position p in an N-cycle period.
   task automatic run(input int n, input int p0, input int cycles, input logic [7:0] act, input logic rdy);
      for (int i = 0; i < cycles; i++) begin
         int p;
         p = (p0 + i) % n;
         cyc(1'b1, 1'b1, 1'b0, 8'd0, p < (n / 2), p == 0, act, rdy, 1'b0, 1'b1);
      end
   endtask

   initial begin
      rst = 1'b0; en = 1'b0; cfg.cfg_valid = 1'b0; cfg.cfg_div = 8'd0;

      // reset, then idle with ready high
      repeat (3) cyc(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd7, 1'b0, 1'b0, 1'b0);
      repeat (2) cyc(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd7, 1'b1, 1'b0, 1'b0);

      // N=7 for 21 cycles: 1110000 x3, tick every 7
      run(7, 0, 21, 8'd7, 1'b1);

      // request 4 at cnt=2: PEND until boundary, then 1100
      run(7, 0, 3, 8'd7, 1'b1);
      cyc(1'b1, 1'b1, 1'b1, 8'd4, 1'b0, 1'b0, 8'd7, 1'b0, 1'b0, 1'b1);
      run(7, 4, 3, 8'd7, 1'b0);
      run(4, 0, 8, 8'd4, 1'b1);

      // requests on the wrap edge take effect immediately
      cyc(1'b1, 1'b1, 1'b1, 8'd7, 1'b1, 1'b1, 8'd7, 1'b1, 1'b0, 1'b1);
      run(7, 1, 6, 8'd7, 1'b1);
      cyc(1'b1, 1'b1, 1'b1, 8'd5, 1'b1, 1'b1, 8'd5, 1'b1, 1'b0, 1'b1);
      run(5, 1, 9, 8'd5, 1'b1);

      // illegal ratios 1 then 0: one err pulse each, waveform unchanged
      cyc(1'b1, 1'b1, 1'b1, 8'd1, 1'b1, 1'b1, 8'd5, 1'b1, 1'b1, 1'b1);
      cyc(1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 8'd5, 1'b1, 1'b0, 1'b1);
      cyc(1'b1, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0, 8'd5, 1'b1, 1'b1, 1'b1);
      run(5, 3, 5, 8'd5, 1'b1);

      // PEND with 9, drop en: idle with 9 applied, restart ticks next cycle
      cyc(1'b1, 1'b1, 1'b1, 8'd9, 1'b0, 1'b0, 8'd5, 1'b0, 1'b0, 1'b1);
      repeat (2) cyc(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd9, 1'b1, 1'b0, 1'b0);
      run(9, 0, 9, 8'd9, 1'b1);

      // reset while in PEND at N=9: pending ratio and partial period discarded
      run(9, 0, 3, 8'd9, 1'b1);
      cyc(1'b1, 1'b1, 1'b1, 8'd3, 1'b1, 1'b0, 8'd9, 1'b0, 1'b0, 1'b1);
      repeat (2) cyc(1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 8'd7, 1'b0, 1'b0, 1'b0);
      repeat (2) cyc(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd7, 1'b1, 1'b0, 1'b0);
      run(7, 0, 9, 8'd7, 1'b1);

      // stop and legal accept on the same edge, then idle accepts, minimum ratio 2
      cyc(1'b1, 1'b0, 1'b1, 8'd3, 1'b0, 1'b0, 8'd3, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b1, 8'd2, 1'b0, 1'b0, 8'd2, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b1, 8'd1, 1'b0, 1'b0, 8'd2, 1'b1, 1'b1, 1'b0);
      run(2, 0, 4, 8'd2, 1'b1);

      @(negedge clk);
      cfg.cfg_valid = 1'b0;
      @(posedge clk);
      #3;
      total++;
      assert (sb.size() == 0) else begin
         bad++;
         $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
